// File: rtl/booth_r4_multiplier.sv
// Sequential radix-4 (modified Booth) multiplier with start/busy/done handshake.
// Retires two multiplier bits per CALC cycle; signed/unsigned selected per operation.
module booth_r4_multiplier #(
  parameter int unsigned N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int unsigned W  = N + 2;
  localparam int unsigned AW = W + 2;
  localparam int unsigned K  = W / 2;
  localparam int unsigned CW = $clog2(K + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    a_q, a_d;
  logic [W-1:0]     q_q, q_d;
  logic             q1_q, q1_d;
  logic [W-1:0]     mx_q, mx_d;
  logic [CW-1:0]    count_q, count_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [2*N-1:0]   product_q, product_d;

  logic [AW-1:0]    mx_wide;
  logic [AW-1:0]    term;
  logic [AW-1:0]    sum;
  logic             accept;

  // Booth recoding of {Q[1],Q[0],q_1} into a multiple of the multiplicand
  always_comb begin
    mx_wide = {{2{mx_q[W-1]}}, mx_q};
    term    = '0;
    unique case ({q_q[1:0], q1_q})
      3'b001, 3'b010: term = mx_wide;
      3'b011:         term = {mx_wide[AW-2:0], 1'b0};
      3'b100:         term = ~{mx_wide[AW-2:0], 1'b0} + AW'(1);
      3'b101, 3'b110: term = ~mx_wide + AW'(1);
      default:        term = '0;
    endcase
    sum = a_q + term;
  end

  assign accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    q_d       = q_q;
    q1_d      = q1_q;
    mx_d      = mx_q;
    count_d   = count_q;
    done_d    = 1'b0;
    product_d = product_q;

    unique case (state_q)
      S_CALC: begin
        a_d     = {{2{sum[AW-1]}}, sum[AW-1:2]};
        q_d     = {sum[1:0], q_q[W-1:2]};
        q1_d    = q_q[1];
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_d    = 1'b1;
        product_d = {a_q[N-3:0], q_q};
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Acceptance from IDLE or DONE; DONE acceptance gives back-to-back operation
    if (accept) begin
      mx_d    = signed_mode ? {{2{multiplicand[N-1]}}, multiplicand} : {2'b00, multiplicand};
      q_d     = signed_mode ? {{2{multiplier[N-1]}}, multiplier} : {2'b00, multiplier};
      a_d     = '0;
      q1_d    = 1'b0;
      count_d = CW'(K);
      state_d = S_CALC;
    end

    busy_d = (state_d == S_CALC);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      q_q       <= '0;
      q1_q      <= 1'b0;
      mx_q      <= '0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      q_q       <= q_d;
      q1_q      <= q1_d;
      mx_q      <= mx_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_booth_r4_multiplier.sv
// Self-checking bench for booth_r4_multiplier: directed corner cases, handshake,
// reset abort, back-to-back starts and a random sweep at N=8 and N=16.
module tb_booth_r4_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        st8, sm8, st16, sm16;
  logic [7:0]  a8, b8;
  logic [15:0] a16, b16;
  logic        busy8, done8, busy16, done16;
  logic [15:0] p8;
  logic [31:0] p16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  booth_r4_multiplier #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .start(st8), .signed_mode(sm8),
    .multiplicand(a8), .multiplier(b8),
    .busy(busy8), .done(done8), .product(p8)
  );

  booth_r4_multiplier #(.N(16)) dut16 (
    .clk(clk), .rst(rst), .start(st16), .signed_mode(sm16),
    .multiplicand(a16), .multiplier(b16),
    .busy(busy16), .done(done16), .product(p16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer product of the interpreted operands, truncated to 2n bits
  function automatic logic [31:0] ref_mul(input int n, input bit sm,
                                          input logic [15:0] a, input logic [15:0] b);
    longint x, y, p;
    x = longint'(a);
    y = longint'(b);
    if (sm && a[n-1]) x = x - (longint'(1) << n);
    if (sm && b[n-1]) y = y - (longint'(1) << n);
    p = x * y;
    return 32'(p & ((longint'(1) << (2 * n)) - 1));
  endfunction

  task automatic run8(input string tag, input bit sm, input logic [7:0] a,
                      input logic [7:0] b, input logic [15:0] exp);
    int cyc;
    sm8 = sm; a8 = a; b8 = b; st8 = 1'b1;
    tick();
    st8 = 1'b0; sm8 = ~sm; a8 = 8'($urandom); b8 = 8'($urandom);
    cyc = 0;
    while (!done8 && cyc < 20) begin
      tick();
      cyc++;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'd6);
    chk(tag, {16'h0, p8}, {16'h0, exp});
    tick();
    chk({tag, "_pulse"}, {31'h0, done8}, 32'd0);
  endtask

  initial begin
    logic [15:0] q8[$];
    logic [15:0] e8, prev8, head;
    logic [31:0] e16, prev16;
    int dc8, dc16, dcy8, dcy16, cyc, last_done, r;

    rst = 1'b1; st8 = 1'b0; st16 = 1'b0; sm8 = 1'b0; sm16 = 1'b0;
    a8 = '0; b8 = '0; a16 = '0; b16 = '0;
    tick(); tick();
    chk("rst_busy8", {31'h0, busy8}, 32'd0);
    chk("rst_done8", {31'h0, done8}, 32'd0);
    chk("rst_prod8", {16'h0, p8}, 32'd0);
    chk("rst_busy16", {31'h0, busy16}, 32'd0);
    chk("rst_prod16", p16, 32'd0);
    rst = 1'b0;
    tick();

    run8("m3x5", 1'b1, 8'hFD, 8'h05, 16'hFFF1);
    run8("n128xn128", 1'b1, 8'h80, 8'h80, 16'h4000);
    run8("n128x127", 1'b1, 8'h80, 8'h7F, 16'hC080);
    run8("u255x255", 1'b0, 8'hFF, 8'hFF, 16'hFE01);
    run8("u0x200", 1'b0, 8'h00, 8'hC8, 16'h0000);
    run8("s0xn1", 1'b1, 8'hFF, 8'h00, 16'h0000);

    // Reset during the third CALC cycle abandons the operation
    sm8 = 1'b1; a8 = 8'h11; b8 = 8'h22; st8 = 1'b1;
    tick();
    st8 = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", {31'h0, busy8}, 32'd0);
    chk("abort_done", {31'h0, done8}, 32'd0);
    chk("abort_prod", {16'h0, p8}, 32'd0);
    dc8 = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (done8) dc8++;
    end
    chk("abort_no_done", 32'(dc8), 32'd0);
    run8("after_abort", 1'b1, 8'h9C, 8'h37, 16'(ref_mul(8, 1'b1, 16'h009C, 16'h0037)));

    // Start held high with changing operands: only idle-time captures count
    q8.delete();
    cyc = 0; last_done = -1; dc8 = 0;
    st8 = 1'b1;
    for (int c = 0; c < 40; c++) begin
      sm8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
      if (!busy8) q8.push_back(16'(ref_mul(8, sm8, {8'h0, a8}, {8'h0, b8})));
      tick();
      cyc++;
      if (done8) begin
        dc8++;
        head = (q8.size() > 0) ? q8.pop_front() : 16'hxxxx;
        chk("b2b_prod", {16'h0, p8}, {16'h0, head});
        if (last_done >= 0) chk("b2b_interval", 32'(cyc - last_done), 32'd6);
        last_done = cyc;
      end
    end
    st8 = 1'b0;
    for (int c = 0; c < 20 && q8.size() > 0; c++) begin
      tick();
      if (done8) begin
        dc8++;
        head = q8.pop_front();
        chk("b2b_drain", {16'h0, p8}, {16'h0, head});
      end
    end
    chk("b2b_queue_empty", 32'(q8.size()), 32'd0);
    chk("b2b_done_count", 32'(dc8), 32'd7);

    // Random sweep on both widths, started together each round
    for (int it = 0; it < 5000; it++) begin
      r = int'($urandom_range(0, 9));
      a8  = (r == 0) ? 8'h00 : (r == 1) ? 8'h80 : (r == 2) ? 8'hFF : 8'($urandom);
      a16 = (r == 3) ? 16'h0000 : (r == 4) ? 16'h8000 : (r == 5) ? 16'hFFFF : 16'($urandom);
      b8  = (r == 6) ? 8'h7F : 8'($urandom);
      b16 = (r == 7) ? 16'h7FFF : 16'($urandom);
      sm8 = 1'($urandom); sm16 = 1'($urandom);
      e8  = 16'(ref_mul(8, sm8, {8'h0, a8}, {8'h0, b8}));
      e16 = ref_mul(16, sm16, a16, b16);
      prev8 = p8; prev16 = p16;
      st8 = 1'b1; st16 = 1'b1;
      tick();
      st8 = 1'b0; st16 = 1'b0;
      sm8 = ~sm8; sm16 = ~sm16;
      a8 = 8'($urandom); b8 = 8'($urandom); a16 = 16'($urandom); b16 = 16'($urandom);
      dc8 = 0; dc16 = 0; dcy8 = 0; dcy16 = 0;
      for (int c = 1; c <= 11; c++) begin
        tick();
        if (c == 5) chk("hold8", {16'h0, p8}, {16'h0, prev8});
        if (c == 9) chk("hold16", p16, prev16);
        if (done8) begin dc8++; dcy8 = c; end
        if (done16) begin dc16++; dcy16 = c; end
      end
      chk("rnd_done8_cnt", 32'(dc8), 32'd1);
      chk("rnd_done8_cyc", 32'(dcy8), 32'd6);
      chk("rnd_prod8", {16'h0, p8}, {16'h0, e8});
      chk("rnd_done16_cnt", 32'(dc16), 32'd1);
      chk("rnd_done16_cyc", 32'(dcy16), 32'd10);
      chk("rnd_prod16", p16, e16);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
